// File: rtl/rvfi_commit_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rvfi_commit_sequencer (with package rvfi_pkg)                 |
// | Purpose  : Packs the per-cycle RVFI commit ports into one in-order       |
// |            stream for the trace writer. Buffers up to FIFO_DEPTH         |
// |            retired/trapped entries, drains one per valid/ready handshake,|
// |            and owns simulation-end control (drained ECALL or timeout).   |
// | Ports    : clk_i, rst_i (async, active-high)                             |
// |            rvfi_i[NR_COMMIT_PORTS]  commit ports, port 0 oldest          |
// |            trace_valid_o/trace_ready_i/trace_o  head-of-FIFO stream      |
// |            overflow_o, drop_cnt_o   sticky drop flag, saturating count   |
// |            halt_o, timeout_o        simulation end reason                |
// |            cycles_o, instret_o      cycle count, drained-valid count     |
// | Options  : RVFI_SEQ_INSTRET_EN - build the 64-bit instret_o counter;     |
// |            when undefined instret_o is tied to zero.                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+

package rvfi_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap;
    logic        halt;
    logic        intr;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
  } rvfi_instr_t;
endpackage

module rvfi_commit_sequencer
  import rvfi_pkg::*;
#(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int FIFO_DEPTH      = 8,
  parameter int TIMEOUT         = 200000
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_i,
  output logic                              trace_valid_o,
  input  logic                              trace_ready_i,
  output rvfi_instr_t                       trace_o,
  output logic                              overflow_o,
  output logic [15:0]                       drop_cnt_o,
  output logic                              halt_o,
  output logic                              timeout_o,
  output logic [31:0]                       cycles_o,
  output logic [63:0]                       instret_o
);

  localparam int              c_AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              c_CW       = $clog2(FIFO_DEPTH + NR_COMMIT_PORTS + 1);
  localparam int              c_PW       = (NR_COMMIT_PORTS > 1) ? $clog2(NR_COMMIT_PORTS) : 1;
  localparam logic [c_AW-1:0] c_PTR_MASK = c_AW'(FIFO_DEPTH - 1);
  localparam logic [c_CW-1:0] c_DEPTH    = c_CW'(FIFO_DEPTH);
  localparam logic [31:0]     c_ECALL    = 32'h00000073;
  localparam logic [31:0]     c_TIMEOUT  = 32'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  rvfi_instr_t     r_mem [FIFO_DEPTH];
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_CW-1:0] r_count;
  logic            r_overflow;
  logic [15:0]     r_drop_cnt;
  logic            r_halt;
  logic            r_timeout;
  logic [31:0]     r_cycles;

  rvfi_instr_t [NR_COMMIT_PORTS-1:0] w_pk;
  logic [c_CW-1:0] w_n_elig;
  logic [c_CW-1:0] w_space;
  logic [c_CW-1:0] w_n_fit;
  logic [c_CW-1:0] w_ecall_len;
  logic [c_CW-1:0] w_n_push;
  logic [c_CW-1:0] w_n_drop;
  logic            w_hit;
  logic            w_pop;
  logic            w_head_ecall;
  logic [16:0]     w_drop_sum;

  // Compact eligible ports into consecutive slots, preserving port order.
  always_comb begin
    w_pk     = '0;
    w_n_elig = '0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      if (rvfi_i[i].valid || rvfi_i[i].trap) begin
        w_pk[w_n_elig[c_PW-1:0]] = rvfi_i[i];
        w_n_elig                 = w_n_elig + c_CW'(1);
      end
    end
  end

  // Space is taken before this cycle's pop, so a pop never frees room for a
  // same-cycle push. A written ECALL truncates the packed group right after
  // itself; those trailing entries are discarded, not counted as drops.
  always_comb begin
    w_space     = c_DEPTH - r_count;
    w_n_fit     = (w_n_elig < w_space) ? w_n_elig : w_space;
    w_hit       = 1'b0;
    w_ecall_len = '0;
    for (int j = 0; j < NR_COMMIT_PORTS; j++) begin
      if (!w_hit && (c_CW'(j) < w_n_fit) && w_pk[j].valid && (w_pk[j].insn == c_ECALL)) begin
        w_hit       = 1'b1;
        w_ecall_len = c_CW'(j + 1);
      end
    end
    w_n_push = '0;
    w_n_drop = '0;
    if (r_state == ST_RUN) begin
      if (w_hit) begin
        w_n_push = w_ecall_len;
      end else begin
        w_n_push = w_n_fit;
        w_n_drop = w_n_elig - w_n_fit;
      end
    end
  end

  assign trace_valid_o = (r_count != '0) && (r_state != ST_DONE);
  assign trace_o       = r_mem[r_rd_ptr];
  assign w_pop         = trace_valid_o && trace_ready_i;
  assign w_head_ecall  = trace_o.valid && (trace_o.insn == c_ECALL);
  assign w_drop_sum    = {1'b0, r_drop_cnt} + 17'(w_n_drop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_RUN;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
      r_halt     <= 1'b0;
      r_timeout  <= 1'b0;
      r_cycles   <= '0;
    end else begin
      r_rd_ptr <= (r_rd_ptr + c_AW'(w_pop)) & c_PTR_MASK;
      r_wr_ptr <= (r_wr_ptr + c_AW'(w_n_push)) & c_PTR_MASK;
      r_count  <= r_count + w_n_push - c_CW'(w_pop);

      if (w_n_drop != '0) begin
        r_overflow <= 1'b1;
        r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      end

      if (r_state != ST_DONE) begin
        r_cycles <= r_cycles + 32'd1;
      end

      // Timeout takes priority over a simultaneous ECALL completion.
      if ((r_state != ST_DONE) && (r_cycles > c_TIMEOUT)) begin
        r_state   <= ST_DONE;
        r_timeout <= 1'b1;
      end else begin
        case (r_state)
          ST_RUN: begin
            if (w_hit) begin
              r_state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            // No pushes happen in DRAIN, so the only ECALL left is the one
            // that caused the transition.
            if (w_pop && w_head_ecall) begin
              r_state <= ST_DONE;
              r_halt  <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Storage carries no reset; occupancy is governed by r_count alone.
  always_ff @(posedge clk_i) begin
    for (int j = 0; j < NR_COMMIT_PORTS; j++) begin
      if (c_CW'(j) < w_n_push) begin
        r_mem[(r_wr_ptr + c_AW'(j)) & c_PTR_MASK] <= w_pk[j];
      end
    end
  end

  assign overflow_o = r_overflow;
  assign drop_cnt_o = r_drop_cnt;
  assign halt_o     = r_halt;
  assign timeout_o  = r_timeout;
  assign cycles_o   = r_cycles;

`ifdef RVFI_SEQ_INSTRET_EN
  logic [63:0] r_instret;

  // Pops cannot occur in DONE, so the counter freezes there naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_instret <= '0;
    end else if (w_pop && trace_o.valid) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  assign instret_o = r_instret;
`else
  assign instret_o = 64'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rvfi_commit_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_rvfi_commit_sequencer                                      |
// | Purpose  : Self-checking bench for rvfi_commit_sequencer. A queue-based  |
// |            reference model tracks the expected stream and status.        |
// | Options  : RVFI_SEQ_INSTRET_EN - selects the expected instret_o values.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_rvfi_commit_sequencer;
  import rvfi_pkg::*;

  localparam int          NR    = 2;
  localparam int          DEPTH = 8;
  localparam int          TMO   = 100;
  localparam logic [31:0] ECALL = 32'h00000073;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b0;
  rvfi_instr_t [NR-1:0]  rvfi_i = '0;
  logic                  trace_valid_o;
  logic                  trace_ready_i = 1'b0;
  rvfi_instr_t           trace_o;
  logic                  overflow_o;
  logic [15:0]           drop_cnt_o;
  logic                  halt_o;
  logic                  timeout_o;
  logic [31:0]           cycles_o;
  logic [63:0]           instret_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  rvfi_commit_sequencer #(
    .NR_COMMIT_PORTS(NR),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT        (TMO)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rvfi_i       (rvfi_i),
    .trace_valid_o(trace_valid_o),
    .trace_ready_i(trace_ready_i),
    .trace_o      (trace_o),
    .overflow_o   (overflow_o),
    .drop_cnt_o   (drop_cnt_o),
    .halt_o       (halt_o),
    .timeout_o    (timeout_o),
    .cycles_o     (cycles_o),
    .instret_o    (instret_o)
  );

  // ---------------- reference model ----------------
  rvfi_instr_t     mq[$];
  bit              m_drain, m_done, m_halt, m_tmo;
  int              m_drops;
  logic [31:0]     m_cycles;
  logic [63:0]     m_instret;

  function automatic rvfi_instr_t mk(bit v, bit t, logic [31:0] insn, logic [31:0] pc);
    rvfi_instr_t e;
    e          = '0;
    e.valid    = v;
    e.trap     = t;
    e.insn     = insn;
    e.pc_rdata = pc;
    e.pc_wdata = pc + 32'd4;
    e.order    = 64'(pc);
    e.rd_addr  = pc[6:2];
    e.rd_wdata = ~pc;
    return e;
  endfunction

  function automatic logic [63:0] exp_instret(logic [63:0] n);
`ifdef RVFI_SEQ_INSTRET_EN
    return n;
`else
    return 64'h0 & n;
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    m_drain   = 1'b0;
    m_done    = 1'b0;
    m_halt    = 1'b0;
    m_tmo     = 1'b0;
    m_drops   = 0;
    m_cycles  = '0;
    m_instret = '0;
  endtask

  task automatic model_step();
    bit          was_done  = m_done;
    bit          was_drain = m_drain;
    int          space     = DEPTH - mq.size();
    bit          pop;
    int          k;
    rvfi_instr_t head = '0;
    pop = (mq.size() != 0) && !was_done && trace_ready_i;
    if (pop) head = mq.pop_front();
    if (!was_done && !was_drain) begin
      k = 0;
      for (int i = 0; i < NR; i++) begin
        if (rvfi_i[i].valid || rvfi_i[i].trap) begin
          if (m_drain) begin
            // after a written ECALL: silently discarded
          end else if (k >= space) begin
            m_drops++;
          end else begin
            mq.push_back(rvfi_i[i]);
            k++;
            if (rvfi_i[i].valid && rvfi_i[i].insn == ECALL) m_drain = 1'b1;
          end
        end
      end
    end
    if (pop && was_drain && head.valid && head.insn == ECALL) begin
      m_done = 1'b1;
      m_halt = 1'b1;
    end
    if (!was_done && m_cycles > 32'(TMO)) begin
      m_done = 1'b1;
      m_tmo  = 1'b1;
      m_halt = 1'b0;
    end
    if (!was_done) m_cycles = m_cycles + 32'd1;
    if (pop && head.valid) m_instret = m_instret + 64'd1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rvfi_i        = '0;
    trace_ready_i = 1'b0;
    rst_i         = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", trace_valid_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b want 0", overflow_o); end
    checks++; if (drop_cnt_o !== 16'd0) begin errors++; $display("FAIL rst_drop got %0d want 0", drop_cnt_o); end
    checks++; if (halt_o !== 1'b0) begin errors++; $display("FAIL rst_halt got %b want 0", halt_o); end
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL rst_timeout got %b want 0", timeout_o); end
    checks++; if (cycles_o !== 32'd0) begin errors++; $display("FAIL rst_cycles got %0d want 0", cycles_o); end
    checks++; if (instret_o !== 64'd0) begin errors++; $display("FAIL rst_instret got %0d want 0", instret_o); end
  endtask

  task automatic test_single_commit();
    do_reset();
    trace_ready_i = 1'b1;
    rvfi_i[0]     = mk(1'b1, 1'b0, 32'h00000013, 32'h80000000);
    tick();
    rvfi_i = '0;
    checks++; if (trace_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", trace_valid_o); end
    checks++; if (trace_o.pc_rdata !== 32'h80000000) begin errors++; $display("FAIL single_pc got %h want 80000000", trace_o.pc_rdata); end
    checks++; if (cycles_o !== 32'd1) begin errors++; $display("FAIL single_cycles got %0d want 1", cycles_o); end
    tick();
    checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("FAIL single_drained got %b want 0", trace_valid_o); end
  endtask

  task automatic test_pair();
    do_reset();
    trace_ready_i = 1'b1;
    rvfi_i[0]     = mk(1'b1, 1'b0, 32'h00000013, 32'h00000100);
    rvfi_i[1]     = mk(1'b1, 1'b0, 32'h00000013, 32'h00000104);
    tick();
    rvfi_i = '0;
    checks++; if (trace_o.pc_rdata !== 32'h100) begin errors++; $display("FAIL pair_first got %h want 100", trace_o.pc_rdata); end
    tick();
    checks++; if (trace_valid_o !== 1'b1 || trace_o.pc_rdata !== 32'h104) begin
      errors++; $display("FAIL pair_second got v=%b pc=%h want v=1 pc=104", trace_valid_o, trace_o.pc_rdata); end
    tick();
    checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("FAIL pair_empty got %b want 0", trace_valid_o); end
    checks++; if (instret_o !== exp_instret(64'd2)) begin errors++; $display("FAIL pair_instret got %0d want %0d", instret_o, exp_instret(64'd2)); end
  endtask

  task automatic test_overflow();
    do_reset();
    trace_ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      rvfi_i[0] = mk(1'b1, 1'b0, 32'h00000013, 32'h1000 + 32'(8 * c));
      rvfi_i[1] = mk(1'b1, 1'b0, 32'h00000013, 32'h1004 + 32'(8 * c));
      tick();
      checks++; if (trace_o.pc_rdata !== 32'h1000) begin errors++; $display("FAIL ovf_stable c%0d got %h want 1000", c, trace_o.pc_rdata); end
    end
    rvfi_i = '0;
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow_o); end
    checks++; if (drop_cnt_o !== 16'd2) begin errors++; $display("FAIL ovf_drops got %0d want 2", drop_cnt_o); end
    trace_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++; if (trace_valid_o !== 1'b1 || trace_o.pc_rdata !== 32'h1000 + 32'(4 * k)) begin
        errors++; $display("FAIL ovf_order k%0d got v=%b pc=%h want v=1 pc=%h", k, trace_valid_o, trace_o.pc_rdata, 32'h1000 + 32'(4 * k)); end
      tick();
    end
    checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b want 0", trace_valid_o); end
  endtask

  task automatic test_ecall();
    do_reset();
    trace_ready_i = 1'b0;
    rvfi_i[0]     = mk(1'b1, 1'b0, 32'h00000013, 32'h200);
    rvfi_i[1]     = mk(1'b1, 1'b0, ECALL, 32'h204);
    tick();
    rvfi_i[0]     = mk(1'b1, 1'b0, 32'h00000013, 32'h300);
    rvfi_i[1]     = mk(1'b1, 1'b0, 32'h00000013, 32'h304);
    trace_ready_i = 1'b1;
    checks++; if (trace_o.pc_rdata !== 32'h200) begin errors++; $display("FAIL ecall_first got %h want 200", trace_o.pc_rdata); end
    tick();
    checks++; if (trace_valid_o !== 1'b1 || trace_o.insn !== ECALL) begin
      errors++; $display("FAIL ecall_head got v=%b insn=%h want v=1 insn=%h", trace_valid_o, trace_o.insn, ECALL); end
    tick();
    checks++; if (halt_o !== 1'b1) begin errors++; $display("FAIL ecall_halt got %b want 1", halt_o); end
    checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("FAIL ecall_valid got %b want 0", trace_valid_o); end
    for (int c = 0; c < 4; c++) tick();
    rvfi_i = '0;
    checks++; if (drop_cnt_o !== 16'd0 || overflow_o !== 1'b0) begin
      errors++; $display("FAIL ecall_drops got %0d/%b want 0/0", drop_cnt_o, overflow_o); end
    checks++; if (cycles_o !== 32'd3) begin errors++; $display("FAIL ecall_cycles got %0d want 3", cycles_o); end
    checks++; if (timeout_o !== 1'b0 || halt_o !== 1'b1) begin
      errors++; $display("FAIL ecall_end got t=%b h=%b want t=0 h=1", timeout_o, halt_o); end
  endtask

  task automatic test_ecall_first();
    do_reset();
    trace_ready_i = 1'b1;
    rvfi_i[0]     = mk(1'b1, 1'b0, ECALL, 32'h500);
    rvfi_i[1]     = mk(1'b1, 1'b0, 32'h00000013, 32'h504);
    tick();
    rvfi_i = '0;
    checks++; if (trace_o.pc_rdata !== 32'h500) begin errors++; $display("FAIL ecall0_head got %h want 500", trace_o.pc_rdata); end
    tick();
    checks++; if (halt_o !== 1'b1 || drop_cnt_o !== 16'd0) begin
      errors++; $display("FAIL ecall0_end got h=%b d=%0d want h=1 d=0", halt_o, drop_cnt_o); end
    checks++; if (instret_o !== exp_instret(64'd1)) begin errors++; $display("FAIL ecall0_instret got %0d want %0d", instret_o, exp_instret(64'd1)); end
  endtask

  task automatic test_timeout();
    bit reached = 1'b0;
    do_reset();
    trace_ready_i = 1'b0;
    rvfi_i[0]     = mk(1'b1, 1'b0, 32'h00000013, 32'h600);
    tick();
    rvfi_i = '0;
    for (int c = 0; c < 200 && !reached; c++) begin
      tick();
      if (cycles_o === 32'd101) reached = 1'b1;
    end
    checks++; if (!reached) begin errors++; $display("FAIL tmo_reach got %0d want 101", cycles_o); end
    checks++; if (timeout_o !== 1'b0 || trace_valid_o !== 1'b1) begin
      errors++; $display("FAIL tmo_before got t=%b v=%b want t=0 v=1", timeout_o, trace_valid_o); end
    tick();
    checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL tmo_flag got %b want 1", timeout_o); end
    checks++; if (trace_valid_o !== 1'b0 || halt_o !== 1'b0) begin
      errors++; $display("FAIL tmo_state got v=%b h=%b want v=0 h=0", trace_valid_o, halt_o); end
    for (int c = 0; c < 3; c++) tick();
    checks++; if (cycles_o !== 32'd102) begin errors++; $display("FAIL tmo_frozen got %0d want 102", cycles_o); end
  endtask

  task automatic test_reset_flush();
    do_reset();
    trace_ready_i = 1'b1;
    rvfi_i[0]     = mk(1'b1, 1'b0, 32'h00000013, 32'h400);
    rvfi_i[1]     = mk(1'b1, 1'b0, 32'h00000013, 32'h404);
    tick();
    rvfi_i = '0;
    tick();
    tick();
    trace_ready_i = 1'b0;
    rvfi_i[0]     = mk(1'b1, 1'b0, 32'h00000013, 32'h410);
    rvfi_i[1]     = mk(1'b0, 1'b1, 32'h00000013, 32'h414);
    tick();
    rvfi_i[1] = '0;
    rvfi_i[0] = mk(1'b1, 1'b0, 32'h00000013, 32'h418);
    tick();
    rvfi_i = '0;
    checks++; if (trace_valid_o !== 1'b1) begin errors++; $display("FAIL flush_pre got %b want 1", trace_valid_o); end
    #2;
    rst_i = 1'b1;
    #1;
    checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("FAIL flush_async got %b want 0", trace_valid_o); end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_reset();
    checks++; if (trace_valid_o !== 1'b0 || drop_cnt_o !== 16'd0 || cycles_o !== 32'd0) begin
      errors++; $display("FAIL flush_post got v=%b d=%0d c=%0d want 0/0/0", trace_valid_o, drop_cnt_o, cycles_o); end
    checks++; if (instret_o !== 64'd0) begin errors++; $display("FAIL flush_instret got %0d want 0", instret_o); end
  endtask

  task automatic test_random();
    bit          exp_v;
    logic [15:0] exp_d;
    int          ecall_pct;
    for (int r = 0; r < 6; r++) begin
      do_reset();
      ecall_pct = (r % 2 == 0) ? 4 : 0;
      for (int c = 0; c < 110; c++) begin
        for (int p = 0; p < NR; p++) begin
          rvfi_i[p] = mk($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                         ($urandom_range(0, 99) < ecall_pct) ? ECALL : $urandom,
                         $urandom);
        end
        trace_ready_i = $urandom_range(0, 1) == 1;
        tick();
        exp_v = (mq.size() != 0) && !m_done;
        exp_d = (m_drops > 65535) ? 16'hFFFF : 16'(m_drops);
        checks++; if (trace_valid_o !== exp_v) begin errors++; $display("FAIL rnd_valid r%0d c%0d got %b want %b", r, c, trace_valid_o, exp_v); end
        if (exp_v) begin
          checks++; if (trace_o !== mq[0]) begin errors++; $display("FAIL rnd_head r%0d c%0d got %h want %h", r, c, trace_o, mq[0]); end
        end
        checks++; if (overflow_o !== (m_drops > 0)) begin errors++; $display("FAIL rnd_ovf r%0d c%0d got %b want %b", r, c, overflow_o, m_drops > 0); end
        checks++; if (drop_cnt_o !== exp_d) begin errors++; $display("FAIL rnd_drops r%0d c%0d got %0d want %0d", r, c, drop_cnt_o, exp_d); end
        checks++; if (halt_o !== m_halt || timeout_o !== m_tmo) begin
          errors++; $display("FAIL rnd_end r%0d c%0d got h=%b t=%b want h=%b t=%b", r, c, halt_o, timeout_o, m_halt, m_tmo); end
        checks++; if (cycles_o !== m_cycles) begin errors++; $display("FAIL rnd_cycles r%0d c%0d got %0d want %0d", r, c, cycles_o, m_cycles); end
        checks++; if (instret_o !== exp_instret(m_instret)) begin
          errors++; $display("FAIL rnd_instret r%0d c%0d got %0d want %0d", r, c, instret_o, exp_instret(m_instret)); end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_single_commit();
    test_pair();
    test_overflow();
    test_ecall();
    test_ecall_first();
    test_timeout();
    test_reset_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
